pong_link_tx: RTL and testbench
===============================

Name: pong_link_tx

Overview:
- Serial transmitter for the inter-board paddle link of the two-player pong design.
- Takes the local player's paddle position (10-bit ypos) and left-button state, and sends them over one wire to the peer board as a UART-style frame with parity.
- Runs in the pclk (65 MHz) domain; its inputs come from the mouse-delay stage and its tx output drives the link pin to the peer board.

Parameters:
- CLKS_PER_BIT, 650, clk cycles per bit period (65 MHz / 650 = 100 kbit/s); legal range ≥ 2.
- GAP_BITS, 2, idle bit periods forced after each stop bit before the next start bit; 0 means no gap.

Ports:
- clk  input  1  pixel clock (pclk); all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- send  input  1  request strobe; sampled on every rising edge.
- ypos_in  input  10  local paddle y position to transmit.
- mouse_left_in  input  1  local left-button state to transmit.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame or gap is in progress.
- done  output  1  one-cycle pulse at end of each stop bit.
- frame_cnt  output  8  number of completed frames, wraps 255→0.

Behaviour:
- Reset (asynchronous, immediate, also mid-frame):
  - tx=1, busy=0, done=0, frame_cnt=0.
  - pending=0, state=IDLE, all counters 0.
- Frame order on the wire, 14 bit periods:
  - start bit (0);
  - ypos[0] … ypos[9], LSB first;
  - mouse_left;
  - even parity bit = XOR of the 11 payload bits;
  - stop bit (1).
- Sampling:
  - ypos_in and mouse_left_in are captured into a shift register in the cycle the frame is launched.
  - Input changes after that cycle do not affect the frame in flight.
- States and transitions:
  - IDLE: tx=1, busy=0. On send=1, capture the payload and go to START. tx=0 and busy=1 from the next cycle (1-cycle launch latency).
  - START: after CLKS_PER_BIT cycles, go to DATA.
  - DATA: 11 bit periods, each exactly CLKS_PER_BIT cycles; bit index 0..10, then go to PARITY.
  - PARITY: 1 bit period, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. In the last cycle of STOP, the registered done=1 appears on the following cycle together with frame_cnt+1. Then:
    - go to GAP if GAP_BITS>0;
    - else launch immediately if pending;
    - else go to IDLE.
  - GAP: tx=1, busy=1 for GAP_BITS×CLKS_PER_BIT cycles. Then launch a new frame if pending (fresh capture, pending cleared), else go to IDLE.
- Bit timing:
  - tx is registered, glitch-free, and changes only on bit-period boundaries.
  - A baud counter runs 0..CLKS_PER_BIT-1; a bit advances when the counter equals CLKS_PER_BIT-1.
- Handshake and request queuing:
  - send while busy=1 sets pending=1; this is a single-entry queue, and further requests while pending are merged.
  - send in the same cycle the block returns to IDLE counts as a fresh launch; no request is dropped.
  - The queued frame samples its inputs at launch time, not at request time.
- Back-to-back frames with GAP_BITS=0: the start bit immediately follows the stop bit, and the launch has no idle cycle.
- done and frame_cnt are never asserted for a frame aborted by reset.
- Width rules: the baud counter is $clog2(CLKS_PER_BIT) bits and the gap counter is sized for GAP_BITS×CLKS_PER_BIT; no truncation.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4 → tx=1, busy=0, done=0, frame_cnt=0 held for 100 cycles.
- send pulse, ypos_in=10'h155, mouse_left_in=1, CLKS_PER_BIT=4, GAP_BITS=2:
  - tx goes low 1 cycle later;
  - the line reads 0,1,0,1,0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, left=1, parity=0, stop), each bit 4 cycles;
  - done pulses once, 56 cycles after launch;
  - busy falls 8 cycles after done;
  - frame_cnt=1.
- Parity check, ypos_in=10'h001, mouse_left_in=0 → parity bit=1; ypos_in=10'h3FF, mouse_left_in=1 → parity bit=1 (11 ones).
- send held high continuously, GAP_BITS=0, ypos_in changing each frame:
  - contiguous frames with no idle cycles between them;
  - each frame carries the ypos present at its own launch cycle;
  - frame_cnt wraps 255→0 after 256 frames.
- send pulses at cycles 5, 10 and 20 during a frame → exactly one extra frame follows the first (merged pending); total done pulses=2.
- rst asserted mid-DATA → tx=1 and busy=0 immediately (asynchronous), no done pulse; a send after release transmits a correct full frame.

Source files
------------

// File: rtl/pong_link_tx_if.sv
// Paddle-link transmitter bus: request/payload in, serial line and status out.
interface pong_link_tx_if;
    logic       send;
    logic [9:0] ypos_in;
    logic       mouse_left_in;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] frame_cnt;

    // Requester side: drives the request and payload, observes line and status.
    modport master (
        output send, ypos_in, mouse_left_in,
        input  tx, busy, done, frame_cnt
    );

    // Transmitter side.
    modport slave (
        input  send, ypos_in, mouse_left_in,
        output tx, busy, done, frame_cnt
    );
endinterface

// File: rtl/pong_link_tx.sv
// Serial transmitter for the inter-board paddle link.
// Frame: start(0), ypos[0..9] LSB first, mouse_left, even parity, stop(1),
// followed by an optional forced idle gap. One request can be queued while busy.
module pong_link_tx #(
    parameter int unsigned CLKS_PER_BIT = 650,
    parameter int unsigned GAP_BITS     = 2
) (
    input  logic          clk,
    input  logic          rst,
    pong_link_tx_if.slave link
);

    localparam int unsigned BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned GAP_CYC  = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned PAY_W    = 11;
    localparam int unsigned IDX_W    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [PAY_W-1:0]   shreg_q, shreg_d;
    logic               par_q, par_d;
    logic               pending_q, pending_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               bit_end;
    logic               launch;

    // State and output registers; reset aborts any frame without counting it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            pending_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            pending_q <= pending_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state, bit sequencing, request queuing and launch capture.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        pending_d = pending_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        launch    = 1'b0;
        bit_end   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
        baud_d    = bit_end ? '0 : baud_q + BAUD_W'(1);

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (link.send) begin
                    launch = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[PAY_W-1:1]};
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(PAY_W - 1)) begin
                        state_d = S_PARITY;
                        tx_d    = par_q;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[PAY_W-1:1]};
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    cnt_d  = cnt_q + 8'd1;
                    if (GAP_BITS > 0) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else if (pending_q || link.send) begin
                        launch = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_GAP: begin
                baud_d = '0;
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    if (pending_q || link.send) begin
                        launch = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // A launch consumes the queued request; otherwise requests while busy merge into one.
        if (launch) begin
            pending_d = 1'b0;
        end else if (busy_q && link.send) begin
            pending_d = 1'b1;
        end

        // Payload is sampled only in the launch cycle.
        if (launch) begin
            state_d = S_START;
            baud_d  = '0;
            shreg_d = {link.mouse_left_in, link.ypos_in};
            par_d   = ^{link.mouse_left_in, link.ypos_in};
            tx_d    = 1'b0;
            busy_d  = 1'b1;
        end
    end

    assign link.tx        = tx_q;
    assign link.busy      = busy_q;
    assign link.done      = done_q;
    assign link.frame_cnt = cnt_q;

endmodule

// File: tb/tb_pong_link_tx.sv
// Bench for pong_link_tx: two instances (with and without idle gap), a line
// decoder per instance, and expected-frame queues filled by the stimulus.
module tb_pong_link_tx;

    localparam int unsigned C   = 4;
    localparam int unsigned G0  = 2;
    localparam int unsigned G1  = 0;
    localparam int          NF1 = 257;
    localparam int          FRM = 14 * C;

    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;

    pong_link_tx_if if0();
    pong_link_tx_if if1();

    pong_link_tx #(.CLKS_PER_BIT(C), .GAP_BITS(G0)) dut0 (.clk(clk), .rst(rst0), .link(if0));
    pong_link_tx #(.CLKS_PER_BIT(C), .GAP_BITS(G1)) dut1 (.clk(clk), .rst(rst1), .link(if1));

    typedef struct {
        logic [9:0] y;
        logic       l;
        logic       p;
        logic [7:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int u, input logic [9:0] y, input logic l, input logic p,
                        input logic [7:0] c);
        exp_t e;
        e.y = y; e.l = l; e.p = p; e.cnt = c;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line decoder and scoreboard check for one instance.
    task automatic monitor(input int u);
        int          cyc = 0;
        int          st = -1;
        int          last_start = 0;
        int          done_t = -1;
        int          off;
        int          gap;
        logic        prev = 1'b1;
        logic        busy_prev = 1'b0;
        logic        frame_ok = 1'b0;
        logic [13:0] fr = '0;
        logic        t, b, d, r, empty;
        logic [7:0]  fc;
        exp_t        e;
        gap = (u == 0) ? int'(G0 * C) : int'(G1 * C);
        forever begin
            @(negedge clk);
            cyc++;
            if (u == 0) begin
                t = if0.tx; b = if0.busy; d = if0.done; fc = if0.frame_cnt; r = rst0;
            end else begin
                t = if1.tx; b = if1.busy; d = if1.done; fc = if1.frame_cnt; r = rst1;
            end
            if (r) begin
                st = -1; prev = 1'b1; frame_ok = 1'b0; done_t = -1; busy_prev = 1'b0;
                continue;
            end
            if (d) begin
                empty = (u == 0) ? (q0.size() == 0) : (q1.size() == 0);
                if (empty) begin
                    chk($sformatf("u%0d_done_unexpected", u), int'(d), 0);
                end else begin
                    e = (u == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("u%0d_frame_seen", u), int'(frame_ok), 1);
                    chk($sformatf("u%0d_start_bit", u), int'(fr[0]), 0);
                    chk($sformatf("u%0d_ypos", u), int'(fr[10:1]), int'(e.y));
                    chk($sformatf("u%0d_left", u), int'(fr[11]), int'(e.l));
                    chk($sformatf("u%0d_parity", u), int'(fr[12]), int'(e.p));
                    chk($sformatf("u%0d_stop_bit", u), int'(fr[13]), 1);
                    chk($sformatf("u%0d_frame_cnt", u), int'(fc), int'(e.cnt));
                    chk($sformatf("u%0d_done_latency", u), cyc - last_start, FRM);
                end
                frame_ok = 1'b0;
                done_t   = cyc;
            end
            if (busy_prev && !b && done_t >= 0) begin
                chk($sformatf("u%0d_busy_fall", u), cyc - done_t, gap);
            end
            busy_prev = b;
            if (st < 0 && prev && !t) begin
                st = cyc;
                fr = '0;
            end
            if (st >= 0) begin
                off = cyc - st;
                if (off % C == C / 2) fr[off / C] = t;
                if (off == FRM - 1) begin
                    frame_ok   = 1'b1;
                    last_start = st;
                    st         = -1;
                end
            end
            prev = t;
        end
    endtask

    task automatic send0(input logic [9:0] y, input logic l);
        if0.ypos_in       = y;
        if0.mouse_left_in = l;
        if0.send          = 1'b1;
        tick();
        if0.send = 1'b0;
    endtask

    // Directed sequence on the gapped instance.
    task automatic stim0();
        if0.send = 1'b0; if0.ypos_in = '0; if0.mouse_left_in = 1'b0;
        repeat (3) tick();
        rst0 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_state", int'({if0.tx, if0.busy, if0.done, if0.frame_cnt}), 'h400);
        end
        // 0x155 / left=1: ones=6 -> parity 0
        if0.ypos_in = 10'h155; if0.mouse_left_in = 1'b1; if0.send = 1'b1;
        chk("pre_launch_tx", int'(if0.tx), 1);
        push(0, 10'h155, 1'b1, 1'b0, 8'd1);
        tick();
        if0.send = 1'b0;
        chk("launch_tx_low", int'(if0.tx), 0);
        chk("launch_busy", int'(if0.busy), 1);
        repeat (70) tick();
        // 0x001 / left=0: one 1 -> parity 1
        push(0, 10'h001, 1'b0, 1'b1, 8'd2);
        send0(10'h001, 1'b0);
        repeat (70) tick();
        // 0x3FF / left=1: eleven 1s -> parity 1
        push(0, 10'h3FF, 1'b1, 1'b1, 8'd3);
        send0(10'h3FF, 1'b1);
        repeat (70) tick();
        // Three requests during a frame merge into one queued frame sampled at its launch.
        push(0, 10'h2A3, 1'b0, 1'b1, 8'd4);
        push(0, 10'h0F0, 1'b0, 1'b0, 8'd5);
        send0(10'h2A3, 1'b0);
        for (int i = 1; i <= 25; i++) begin
            if0.send = (i == 5 || i == 10 || i == 20);
            if (i == 22) if0.ypos_in = 10'h0F0;
            tick();
        end
        if0.send = 1'b0;
        repeat (140) tick();
        // Reset in the middle of DATA: frame aborted, no done, counter cleared.
        send0(10'h111, 1'b1);
        repeat (20) tick();
        chk("busy_before_abort", int'(if0.busy), 1);
        @(posedge clk);
        #3 rst0 = 1'b1;
        #1;
        chk("abort_tx_high", int'(if0.tx), 1);
        chk("abort_busy_low", int'(if0.busy), 0);
        tick();
        tick();
        rst0 = 1'b0;
        chk("abort_frame_cnt", int'(if0.frame_cnt), 0);
        chk("abort_done_low", int'(if0.done), 0);
        tick();
        // 0x3C5 / left=1: ones=7 -> parity 1
        push(0, 10'h3C5, 1'b1, 1'b1, 8'd1);
        send0(10'h3C5, 1'b1);
        repeat (80) tick();
    endtask

    // Continuous send on the gapless instance; payload changes every cycle.
    task automatic stim1();
        logic [9:0] y;
        logic       l;
        if1.send = 1'b0; if1.ypos_in = '0; if1.mouse_left_in = 1'b0;
        repeat (3) tick();
        rst1 = 1'b0;
        tick();
        for (int n = 0; n <= (NF1 - 1) * FRM; n++) begin
            y = 10'(n * 7 + 3);
            l = 1'((n >> 3) & 1);
            if1.ypos_in       = y;
            if1.mouse_left_in = l;
            if1.send          = 1'b1;
            if (n % FRM == 0) push(1, y, l, ^{l, y}, 8'((n / FRM) + 1));
            tick();
        end
        if1.send = 1'b0;
        repeat (80) tick();
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none
        fork
            stim0();
            stim1();
        join
        repeat (10) tick();
        chk("u0_frames_missing", q0.size(), 0);
        chk("u1_frames_missing", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
